// File: rtl/coin_collector.sv
// Coin collector FSM: latches a price, accumulates coins, dispenses and returns change.
// Optional customer cancel is compiled in with `define CANCEL_EN.
module coin_collector #(
    parameter int MAX_CREDIT     = 15,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] price,
    input  logic       price_valid,
    input  logic [1:0] coin,
    input  logic       cancel,
    output logic       busy,
    output logic [3:0] credit,
    output logic       dispense,
    output logic [3:0] change,
    output logic       change_valid,
    output logic       coin_reject
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DISPENSE,
        CHANGE,
        REFUND
    } state_t;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [4:0] MAXC = 5'(MAX_CREDIT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [3:0]    price_q;
    logic [TW-1:0] tcount;
    logic [4:0]    coin_val;
    logic [4:0]    sum;
    logic          has_coin;
    logic          fits;
    logic          paid;
    logic          do_cancel;

    always_comb begin
        coin_val = 5'd0;
        unique case (coin)
            2'b01:   coin_val = 5'd1;
            2'b10:   coin_val = 5'd2;
            2'b11:   coin_val = 5'd5;
            default: coin_val = 5'd0;
        endcase
    end

    // Five-bit sum keeps the overflow check from wrapping.
    assign sum      = {1'b0, credit} + coin_val;
    assign fits     = (sum <= MAXC);
    assign paid     = (sum >= {1'b0, price_q});
    assign has_coin = (coin != 2'b00);

`ifdef CANCEL_EN
    assign do_cancel = cancel;
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign do_cancel     = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            price_q      <= 4'd0;
            credit       <= 4'd0;
            tcount       <= '0;
            dispense     <= 1'b0;
            change       <= 4'd0;
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            dispense     <= 1'b0;
            change       <= 4'd0;
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
            unique case (state)
                IDLE: begin
                    coin_reject <= has_coin;
                    if (price_valid && price != 4'd0) begin
                        price_q <= price;
                        credit  <= 4'd0;
                        tcount  <= '0;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (do_cancel) begin
                        coin_reject  <= has_coin;
                        change       <= credit;
                        change_valid <= 1'b1;
                        state        <= REFUND;
                    end else if (has_coin) begin
                        if (fits) begin
                            credit <= sum[3:0];
                            tcount <= '0;
                            if (paid) begin
                                dispense <= 1'b1;
                                state    <= DISPENSE;
                            end
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end else if (tcount == TLAST) begin
                        change       <= credit;
                        change_valid <= 1'b1;
                        state        <= REFUND;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end
                DISPENSE: begin
                    coin_reject  <= has_coin;
                    change       <= credit - price_q;
                    change_valid <= 1'b1;
                    state        <= CHANGE;
                end
                CHANGE, REFUND: begin
                    coin_reject <= has_coin;
                    credit      <= 4'd0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_collector.sv
// Self-checking bench for coin_collector: vector table plus hand sequences,
// expected outputs queued on drive and compared one cycle later.
module tb_coin_collector;

    localparam int T = 16;
    localparam logic [1:0] N  = 2'b00;
    localparam logic [1:0] C1 = 2'b01;
    localparam logic [1:0] C2 = 2'b10;
    localparam logic [1:0] C5 = 2'b11;

    typedef struct {
        logic [3:0] price;
        logic       pv;
        logic [1:0] coin;
        logic       cancel;
        logic       busy;
        logic [3:0] credit;
        logic       disp;
        logic [3:0] chg;
        logic       cv;
        logic       rej;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] price;
    logic       price_valid;
    logic [1:0] coin;
    logic       cancel;
    logic       busy;
    logic [3:0] credit;
    logic       dispense;
    logic [3:0] change;
    logic       change_valid;
    logic       coin_reject;

    int checks = 0;
    int errors = 0;
    vec_t sb[$];
    vec_t tbl[$];

    coin_collector #(
        .MAX_CREDIT(15),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .price(price),
        .price_valid(price_valid),
        .coin(coin),
        .cancel(cancel),
        .busy(busy),
        .credit(credit),
        .dispense(dispense),
        .change(change),
        .change_valid(change_valid),
        .coin_reject(coin_reject)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(logic [3:0] p, logic pv, logic [1:0] c,
                               logic cn, logic b, logic [3:0] cr,
                               logic d, logic [3:0] ch, logic cv,
                               logic rj);
        vec_t r;
        r.price = p;  r.pv = pv;   r.coin = c; r.cancel = cn;
        r.busy = b;   r.credit = cr; r.disp = d;
        r.chg = ch;   r.cv = cv;   r.rej = rj;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        cmp({tag, ".busy"}, {3'b0, busy}, {3'b0, e.busy});
        cmp({tag, ".credit"}, credit, e.credit);
        cmp({tag, ".dispense"}, {3'b0, dispense}, {3'b0, e.disp});
        cmp({tag, ".change"}, change, e.chg);
        cmp({tag, ".change_valid"}, {3'b0, change_valid}, {3'b0, e.cv});
        cmp({tag, ".coin_reject"}, {3'b0, coin_reject}, {3'b0, e.rej});
    endtask

    task automatic step(input vec_t t, input string tag);
        vec_t e;
        price       = t.price;
        price_valid = t.pv;
        coin        = t.coin;
        cancel      = t.cancel;
        sb.push_back(t);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check_all(tag, e);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        price = 4'd0; price_valid = 1'b0; coin = N; cancel = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset", v(0, 0, N, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        @(negedge clk);

        // price 7, coins 5,2: exact payment
        tbl.push_back(v(7, 1, N,  0, 1, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, C5, 0, 1, 5,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, C2, 0, 1, 7,  1, 0, 0, 0));
        tbl.push_back(v(0, 0, N,  0, 1, 7,  0, 0, 1, 0));
        tbl.push_back(v(0, 0, N,  0, 0, 0,  0, 0, 0, 0));
        // price 6, coins 5,5: change 4
        tbl.push_back(v(6, 1, N,  0, 1, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, C5, 0, 1, 5,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, C5, 0, 1, 10, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, N,  0, 1, 10, 0, 4, 1, 0));
        tbl.push_back(v(0, 0, N,  0, 0, 0,  0, 0, 0, 0));
        // price 15: overflow reject, late price ignored, coin in DISPENSE
        tbl.push_back(v(15, 1, N, 0, 1, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, C5, 0, 1, 5,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, C5, 0, 1, 10, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, C2, 0, 1, 12, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, C5, 0, 1, 12, 0, 0, 0, 1));
        tbl.push_back(v(1, 1, C1, 0, 1, 13, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, C2, 0, 1, 15, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, C1, 0, 1, 15, 0, 0, 1, 1));
        tbl.push_back(v(0, 0, N,  0, 0, 0,  0, 0, 0, 0));
        // IDLE: coin rejected, zero price ignored
        tbl.push_back(v(0, 0, C2, 0, 0, 0,  0, 0, 0, 1));
        tbl.push_back(v(0, 1, N,  0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, N,  0, 0, 0,  0, 0, 0, 0));
        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // timeout refund after T coin-free cycles
        step(v(9, 1, N,  0, 1, 0, 0, 0, 0, 0), "tmo_price");
        step(v(0, 0, C2, 0, 1, 2, 0, 0, 0, 0), "tmo_coin");
        for (int k = 1; k < T; k++)
            step(v(0, 0, N, 0, 1, 2, 0, 0, 0, 0), $sformatf("tmo_wait%0d", k));
        step(v(0, 0, N, 0, 1, 2, 0, 2, 1, 0), "tmo_refund");
        step(v(0, 0, N, 0, 0, 0, 0, 0, 0, 0), "tmo_idle");

        // cancel together with a coin
        step(v(9, 1, N,  0, 1, 0, 0, 0, 0, 0), "cn_price");
        step(v(0, 0, C5, 0, 1, 5, 0, 0, 0, 0), "cn_coin");
`ifdef CANCEL_EN
        step(v(0, 0, C2, 1, 1, 5, 0, 5, 1, 1), "cn_refund");
        step(v(0, 0, N,  0, 0, 0, 0, 0, 0, 0), "cn_idle");
        step(v(3, 1, N,  0, 1, 0, 0, 0, 0, 0), "cn0_price");
        step(v(0, 0, N,  1, 1, 0, 0, 0, 1, 0), "cn0_refund");
        step(v(0, 0, N,  0, 0, 0, 0, 0, 0, 0), "cn0_idle");
`else
        step(v(0, 0, C2, 1, 1, 7, 0, 0, 0, 0), "cn_ignored");
        step(v(0, 0, C2, 0, 1, 9, 1, 0, 0, 0), "cn_disp");
        step(v(0, 0, N,  0, 1, 9, 0, 0, 1, 0), "cn_change");
        step(v(0, 0, N,  0, 0, 0, 0, 0, 0, 0), "cn_idle");
        step(v(3, 1, N,  0, 1, 0, 0, 0, 0, 0), "cn0_price");
        step(v(0, 0, N,  1, 1, 0, 0, 0, 0, 0), "cn0_ignored");
        step(v(0, 0, C5, 0, 1, 5, 1, 0, 0, 0), "cn0_disp");
        step(v(0, 0, N,  0, 1, 5, 0, 2, 1, 0), "cn0_change");
        step(v(0, 0, N,  0, 0, 0, 0, 0, 0, 0), "cn0_idle");
`endif

        // asynchronous reset mid-transaction, then coin in IDLE
        step(v(8, 1, N,  0, 1, 0, 0, 0, 0, 0), "rst_price");
        step(v(0, 0, C5, 0, 1, 5, 0, 0, 0, 0), "rst_coin");
        coin = N;
        rst  = 1'b1;
        #1;
        check_all("rst_async", v(0, 0, N, 0, 0, 0, 0, 0, 0, 0));
        #1;
        rst = 1'b0;
        step(v(0, 0, C5, 0, 0, 0, 0, 0, 0, 1), "rst_idle_coin");
        step(v(0, 0, N,  0, 0, 0, 0, 0, 0, 0), "rst_quiet");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
